// File: rtl/dmem_arb_pkg.sv
// Shared types and default sizes for the data-memory arbiter slice.
// Imported by the arbiter top and its wait counter.
package dmem_arb_pkg;

    localparam int ADDR_W_DEF   = 10;
    localparam int DATA_W_DEF   = 32;
    localparam int BE_W_DEF     = DATA_W_DEF / 8;
    localparam int MAX_WAIT_DEF = 4;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    typedef enum logic {
        CORE = 1'b0,
        DBG  = 1'b1
    } arb_owner_t;

    typedef struct packed {
        logic                  we;
        logic [BE_W_DEF-1:0]   be;
        logic [ADDR_W_DEF-1:0] addr;
        logic [DATA_W_DEF-1:0] wdata;
    } mem_req_t;

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int cnt_width(input int max_val);
        if (max_val < 1) begin
            return 1;
        end
        return $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/dmem_wait_counter.sv
// Saturating count of lost arbitrations for the debug port.
// Clear wins over increment; sat_o flags that the count reached MAX.
module dmem_wait_counter
    import dmem_arb_pkg::*;
#(
    parameter int MAX = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam int             W     = cnt_width(MAX);
    localparam logic [W-1:0]   MAX_C = W'(MAX);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    assign sat_o = (count_q == MAX_C);

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (inc_i && !sat_o) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data RAM.
// Core has fixed priority; lock and a starvation bound guarantee debug progress.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic                clk,
    input  logic                reset,

    input  logic                core_req,
    input  logic                core_we,
    input  logic [DATA_W/8-1:0] core_be,
    input  logic [ADDR_W-1:0]   core_addr,
    input  logic [DATA_W-1:0]   core_wdata,
    output logic                core_ack,
    output logic [DATA_W-1:0]   core_rdata,
    output logic                core_stall,

    input  logic                dbg_req,
    input  logic                dbg_we,
    input  logic [DATA_W/8-1:0] dbg_be,
    input  logic [ADDR_W-1:0]   dbg_addr,
    input  logic [DATA_W-1:0]   dbg_wdata,
    input  logic                dbg_lock,
    output logic                dbg_ack,
    output logic [DATA_W-1:0]   dbg_rdata,

    output logic                mem_en,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    arb_state_t state_q;
    arb_state_t state_d;
    arb_owner_t owner_q;
    arb_owner_t owner_d;
    logic       busy_we_q;
    logic       busy_we_d;

    logic       dbg_win;
    logic       core_win;
    logic       wait_inc;
    logic       wait_clr;
    logic       wait_sat;

    // Debug takes the slot when locked, starved, or simply uncontested.
    assign dbg_win  = dbg_req & (dbg_lock | wait_sat | ~core_req);
    assign core_win = core_req & ~dbg_lock & ~dbg_win;

    dmem_wait_counter #(
        .MAX (MAX_WAIT)
    ) u_wait_counter (
        .clk   (clk),
        .reset (reset),
        .inc_i (wait_inc),
        .clr_i (wait_clr),
        .sat_o (wait_sat)
    );

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        busy_we_d = busy_we_q;
        wait_inc  = 1'b0;
        wait_clr  = 1'b0;
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            IDLE: begin
                // The reset term keeps the RAM strobe dead while reset is held.
                if (reset && dbg_win) begin
                    mem_en    = 1'b1;
                    mem_we    = dbg_we;
                    mem_be    = dbg_be;
                    mem_addr  = dbg_addr;
                    mem_wdata = dbg_wdata;
                    owner_d   = DBG;
                    busy_we_d = dbg_we;
                    wait_clr  = 1'b1;
                    state_d   = BUSY;
                end else if (reset && core_win) begin
                    mem_en    = 1'b1;
                    mem_we    = core_we;
                    mem_be    = core_be;
                    mem_addr  = core_addr;
                    mem_wdata = core_wdata;
                    owner_d   = CORE;
                    busy_we_d = core_we;
                    wait_inc  = dbg_req;
                    state_d   = BUSY;
                end
            end
            BUSY: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            owner_q   <= CORE;
            busy_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            owner_q   <= owner_d;
            busy_we_q <= busy_we_d;
        end
    end

    assign core_ack   = (state_q == BUSY) && (owner_q == CORE);
    assign dbg_ack    = (state_q == BUSY) && (owner_q == DBG);
    assign core_rdata = (core_ack && !busy_we_q) ? mem_rdata : '0;
    assign dbg_rdata  = (dbg_ack && !busy_we_q) ? mem_rdata : '0;
    assign core_stall = core_req & ~((state_q == BUSY) && (owner_q == CORE));

    a_one_ack : assert property (@(posedge clk) disable iff (!reset)
        !(core_ack && dbg_ack));

    a_no_en_busy : assert property (@(posedge clk) disable iff (!reset)
        !(mem_en && (state_q == BUSY)));

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Arbitrates one single-port synchronous data RAM between two requesters: the core load/store unit (port 0) and a debug/loader port (port 1).
- The debug port preloads program data, such as the bubble-sort array, and reads results back for checking.
- Sits between core.sv's data-memory interface and the data RAM.
- Fixed core priority, with a starvation bound and a lock so the debug port is guaranteed progress.

Parameters:
- ADDR_W, 10, word-address width.
- DATA_W, 32, data width.
- MAX_WAIT, 4, number of consecutive lost arbitrations after which a pending debug request wins.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- core_req  in  1  core access request; held until core_ack.
- core_we  in  1  core write enable.
- core_be  in  DATA_W/8  core byte enables.
- core_addr  in  ADDR_W  core word address.
- core_wdata  in  DATA_W  core write data.
- core_ack  out  1  one-cycle completion pulse.
- core_rdata  out  DATA_W  read data, valid while core_ack=1.
- core_stall  out  1  core_req high and core is not the current owner.
- dbg_req, dbg_we, dbg_be, dbg_addr, dbg_wdata  in  same widths as the core port  debug request bundle.
- dbg_lock  in  1  while high, the core is never granted.
- dbg_ack  out  1  one-cycle completion pulse.
- dbg_rdata  out  DATA_W  read data, valid while dbg_ack=1.
- mem_en  out  1  RAM access strobe.
- mem_we  out  1  RAM write enable.
- mem_be  out  DATA_W/8  RAM byte enables.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_rdata  in  DATA_W  RAM read data, valid the cycle after mem_en.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, owner=CORE, wait_cnt=0.
  - core_ack=dbg_ack=0, core_rdata=dbg_rdata=0.
  - mem_en=mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
  - mem_en is forced to 0 for as long as reset=0.
- FSM, two states:
  - IDLE: if any request is valid, select a winner.
    - Drive mem_* combinationally from the winner's bundle in this same cycle, with mem_en=1.
    - Register owner and go to BUSY.
    - With no request, mem_en=0 and the FSM stays in IDLE.
  - BUSY: assert the owner's ack for exactly one cycle.
    - Owner's rdata = mem_rdata for reads; for writes it is don't-care and driven 0.
    - mem_en=0. Next state is always IDLE.
- Latency and throughput:
  - Request sampled in IDLE at cycle N, ack in cycle N+1.
  - One access per 2 cycles maximum.
- Handshake:
  - Requester holds req and its bundle stable until the clock edge where it samples ack=1.
  - Requester deasserts req on that edge.
  - A req still high in IDLE after an ack counts as a new request.
- Winner selection in IDLE:
  - Debug wins if dbg_lock=1, or if wait_cnt==MAX_WAIT, or if core_req=0; in each case dbg_req must be 1.
  - Otherwise the core wins if core_req=1 and dbg_lock=0.
  - core_req with dbg_lock=1 and dbg_req=0: no grant; the core keeps stalling.
- wait_cnt:
  - Increments (saturating at MAX_WAIT) on each IDLE decision where dbg_req=1 and the core wins.
  - Clears to 0 whenever debug is granted.
  - Holds otherwise.
- core_stall = core_req & ~(state==BUSY & owner==CORE). Purely combinational.
- Reset mid-access (in BUSY): the ack is not issued. The requester must retry after reset deasserts.
- Asserted invariants:
  - Never core_ack & dbg_ack in the same cycle.
  - mem_en never high in BUSY.

Decomposition:
- Shared package dmem_arb_pkg:
  - typedef arb_state_t {IDLE, BUSY}.
  - typedef arb_owner_t {CORE, DBG}.
  - struct mem_req_t {we, be, addr, wdata}.
  - Default widths.
- Sub-module: dmem_wait_counter, a saturating counter with inc/clr/sat and a MAX parameter.

Test Plan:
- Reset:
  - Stimulus: hold reset=0 for 20 ns with core_req=1.
  - Required response: mem_en=0, acks 0. After release, the first core access appears in the first IDLE cycle.
- Core write then read:
  - Stimulus: write addr 0x010 data 0xDEADBEEF be=4'hF; then read addr 0x010.
  - Required response: each ack arrives 1 cycle after acceptance; the read returns core_rdata=0xDEADBEEF.
- Byte enables:
  - Stimulus: debug writes 0x00000000 to addr 0x020, then the core writes 0x11223344 with be=4'b0101; debug then reads addr 0x020.
  - Required response: dbg_rdata=0x00220044.
- Contention and starvation:
  - Stimulus: core_req held continuously, dbg_req=1.
  - Required response: the core gets 4 grants, then debug is granted on the 5th decision; wait_cnt returns to 0 afterwards.
- Lock, bulk preload:
  - Stimulus: dbg_lock=1; debug writes 10 words {9..0} to addrs 0x000-0x009 while core_req=1.
  - Required response: core_stall stays 1 and no core_ack occurs. After unlock, core reads of addrs 0x000-0x009 return 9..0.
- Reset mid-access:
  - Stimulus: assert reset during BUSY.
  - Required response: no ack is issued and state returns to IDLE; the requester's retry completes normally.
